cg_counter_sched: RTL

- Round-robin scheduler that shares one interval down-counter among NUM_REQ requesters.
- Each requester raises a request with its own delay value. The block grants the counter to one requester, loads that delay, counts it down to zero, then pulses that requester's done bit.
- Sits beside the CG counter datapath. It is the sequencer that preloads the counter, runs it and stops it on behalf of multiple clients, such as timeout and retry logic.

---
 rtl/cg_counter_sched.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/cg_counter_sched.sv
// cg_counter_sched: round-robin sequencer sharing one interval down-counter
// among NUM_REQ requesters. A granted requester's delay is loaded, counted
// down to zero and acknowledged with a one-cycle done pulse.
// Optional build macro CG_COUNTER_SCHED_STOP_EN adds the i_stop input, which
// freezes the countdown while high in RUN.
module cg_counter_sched #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  localparam int unsigned IDX_W     = $clog2(NUM_REQ)
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_delay,
  input  logic                          i_abort,
`ifdef CG_COUNTER_SCHED_STOP_EN
  input  logic                          i_stop,
`endif
  output logic [NUM_REQ-1:0]            o_grant,
  output logic [IDX_W-1:0]              o_grant_idx,
  output logic [NUM_REQ-1:0]            o_done,
  output logic                          o_busy,
  output logic [DATA_WIDTH-1:0]         o_count
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic [NUM_REQ-1:0]    done_q, done_d;
  logic                  busy_q, busy_d;
  logic [DATA_WIDTH-1:0] count_q, count_d;

  logic                  sel_found;
  logic [IDX_W-1:0]      sel_idx;
  int unsigned           pos;
  logic                  stall;
  logic                  cancel;
  logic [IDX_W-1:0]      idx_next;

`ifdef CG_COUNTER_SCHED_STOP_EN
  assign stall = i_stop;
`else
  assign stall = 1'b0;
`endif

  assign cancel   = i_abort | ~i_req[idx_q];
  assign idx_next = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;

  // Arbitration: first active request at or above the pointer, wrapping.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    pos       = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pos = 32'(ptr_q) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      if (!sel_found && i_req[pos[IDX_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = pos[IDX_W-1:0];
      end
    end
  end

  // Next-state and registered-output logic for IDLE / RUN / DONE.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    grant_d = grant_q;
    done_d  = '0;
    busy_d  = busy_q;
    count_d = count_q;
    case (state_q)
      StIdle: begin
        if (sel_found) begin
          state_d          = StRun;
          idx_d            = sel_idx;
          grant_d          = '0;
          grant_d[sel_idx] = 1'b1;
          busy_d           = 1'b1;
          count_d          = i_delay[32'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      StRun: begin
        // Cancel wins over completion and over a stall.
        if (cancel) begin
          state_d = StIdle;
          grant_d = '0;
          busy_d  = 1'b0;
          ptr_d   = idx_next;
        end else if (stall) begin
          state_d = StRun;
        end else if (count_q == '0) begin
          state_d       = StDone;
          grant_d       = '0;
          done_d        = '0;
          done_d[idx_q] = 1'b1;
          ptr_d         = idx_next;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      idx_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign o_grant     = grant_q;
  assign o_grant_idx = idx_q;
  assign o_done      = done_q;
  assign o_busy      = busy_q;
  assign o_count     = count_q;

endmodule
